// File: rtl/syscall_unit_if.sv
// Pipeline/memory/console signal bundle for syscall_unit.
// master is the unit side; slave is the pipeline, memory and console side.
interface syscall_unit_if;
    logic        syscall_valid;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        char_ready;
    logic [31:0] int_out;
    logic        int_valid;
    logic        int_ready;
    logic        done;
    logic        halted;
    logic        err;

    modport master (
        input  syscall_valid, v0, a0, mem_ack, mem_rdata, char_ready, int_ready,
        output stall, mem_req, mem_addr, char_out, char_valid, int_out, int_valid,
               done, halted, err
    );

    modport slave (
        output syscall_valid, v0, a0, mem_ack, mem_rdata, char_ready, int_ready,
        input  stall, mem_req, mem_addr, char_out, char_valid, int_out, int_valid,
               done, halted, err
    );
endinterface

// File: rtl/syscall_unit.sv
// MIPS SYSCALL service unit: print_int, print_string, print_char and exit,
// stalling the pipeline while a service runs.
module syscall_unit #(
    parameter int unsigned MAX_LEN = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    syscall_unit_if.master bus
);
    localparam int unsigned CW = $clog2(MAX_LEN + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] EMIT_C = 3'd2;
    localparam logic [2:0] EMIT_I = 3'd3;
    localparam logic [2:0] HALT   = 3'd4;

    localparam logic [31:0] SYS_PRINT_INT = 32'd1;
    localparam logic [31:0] SYS_PRINT_STR = 32'd4;
    localparam logic [31:0] SYS_EXIT      = 32'd10;
    localparam logic [31:0] SYS_PRINT_CHR = 32'd11;

    logic [2:0]    state;
    logic [31:0]   code_q;
    logic [31:0]   ptr_q;
    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;
    logic [7:0]    char_q;
    logic [31:0]   int_q;
    logic          done_q;
    logic          halted_q;
    logic          err_q;
    logic [7:0]    fetched;

    // Big-endian lane select: byte offset 0 lives in the top byte.
    always_comb begin
        fetched = '0;
        case (ptr_q[1:0])
            2'b00:   fetched = bus.mem_rdata[31:24];
            2'b01:   fetched = bus.mem_rdata[23:16];
            2'b10:   fetched = bus.mem_rdata[15:8];
            default: fetched = bus.mem_rdata[7:0];
        endcase
    end

    assign count_inc = count + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            code_q   <= '0;
            ptr_q    <= '0;
            count    <= '0;
            char_q   <= '0;
            int_q    <= '0;
            done_q   <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.syscall_valid) begin
                        code_q <= bus.v0;
                        ptr_q  <= bus.a0;
                        case (bus.v0)
                            SYS_PRINT_INT: begin
                                int_q <= bus.a0;
                                state <= EMIT_I;
                            end
                            SYS_PRINT_STR: begin
                                count <= '0;
                                state <= FETCH;
                            end
                            SYS_PRINT_CHR: begin
                                char_q <= bus.a0[7:0];
                                state  <= EMIT_C;
                            end
                            SYS_EXIT: begin
                                halted_q <= 1'b1;
                                done_q   <= 1'b1;
                                state    <= HALT;
                            end
                            default: begin
                                err_q  <= 1'b1;
                                done_q <= 1'b1;
                            end
                        endcase
                    end
                end
                FETCH: begin
                    if (bus.mem_ack) begin
                        if (fetched == 8'h00) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            char_q <= fetched;
                            state  <= EMIT_C;
                        end
                    end
                end
                EMIT_C: begin
                    if (bus.char_ready) begin
                        if (code_q == SYS_PRINT_STR) begin
                            ptr_q <= ptr_q + 32'd1;
                            count <= count_inc;
                            if (count_inc == CW'(MAX_LEN)) begin
                                err_q  <= 1'b1;
                                done_q <= 1'b1;
                                state  <= IDLE;
                            end else begin
                                state <= FETCH;
                            end
                        end else begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                EMIT_I: begin
                    if (bus.int_ready) begin
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stall      = (state != IDLE);
    assign bus.mem_req    = (state == FETCH);
    assign bus.mem_addr   = ptr_q;
    assign bus.char_valid = (state == EMIT_C);
    assign bus.char_out   = char_q;
    assign bus.int_valid  = (state == EMIT_I);
    assign bus.int_out    = int_q;
    assign bus.done       = done_q;
    assign bus.halted     = halted_q;
    assign bus.err        = err_q;
endmodule
